// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/control unit.
// The optional FORWARD_EN macro switches between forwarding and stall-only operation.
package pipe_hazard_ctrl_pkg;

  localparam int HC_REG_ADDR_LEN = 5;

  typedef enum logic [1:0] {
    HC_RUN    = 2'd0,
    HC_DRAIN  = 2'd1,
    HC_HALTED = 2'd2
  } hc_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// In-flight destination scoreboard: one entry per write-capable stage after ID,
// entry 0 = EXE, entry DEPTH-1 = WB, plus the per-source match vectors.
module pipe_scoreboard #(
  parameter int REG_ADDR_LEN = 5,
  parameter int DEPTH        = 3,
  parameter bit R0_ZERO      = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    push_wr,
  input  logic [REG_ADDR_LEN-1:0] push_rd,
  input  logic                    push_load,
  input  logic [REG_ADDR_LEN-1:0] rs1,
  input  logic                    rs1_used,
  input  logic [REG_ADDR_LEN-1:0] rs2,
  input  logic                    rs2_used,
  output logic [DEPTH-1:0]        match_a,
  output logic [DEPTH-1:0]        match_b,
  output logic                    load_head
);

  logic [DEPTH-1:0]        valid;
  logic [DEPTH-1:0]        wr;
  logic [DEPTH-1:0]        load;
  logic [REG_ADDR_LEN-1:0] rd [DEPTH];

  // NOTE: only valid strictly needs a reset, but clearing every field keeps
  // the entries free of X so the match compare never propagates unknowns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      wr    <= '0;
      load  <= '0;
      for (int k = 0; k < DEPTH; k++) rd[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments let every entry read its neighbour's
      // pre-edge value, which is what makes this a true shift register.
      valid[0] <= push;
      wr[0]    <= push_wr;
      rd[0]    <= push_rd;
      load[0]  <= push_load;
      for (int k = 1; k < DEPTH; k++) begin
        valid[k] <= valid[k-1];
        wr[k]    <= wr[k-1];
        rd[k]    <= rd[k-1];
        load[k]  <= load[k-1];
      end
    end
  end

  // NOTE: defaults at the top of always_comb guarantee no latch is inferred.
  always_comb begin
    match_a = '0;
    match_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      match_a[k] = rs1_used && valid[k] && wr[k] && (rd[k] == rs1) && !(R0_ZERO && (rs1 == '0));
      match_b[k] = rs2_used && valid[k] && wr[k] && (rd[k] == rs2) && !(R0_ZERO && (rs2 == '0));
    end
  end

  assign load_head = valid[0] && load[0];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/control unit: ID stall, bubble, branch flush, forward selects and halt drain FSM.
// Define FORWARD_EN to enable operand forwarding; otherwise any RAW hazard stalls.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_LEN = HC_REG_ADDR_LEN,
  parameter int DEPTH        = 3,
  parameter bit R0_ZERO      = 1'b1,
  parameter int SEL_W        = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_rs1,
  input  logic                    id_rs1_used,
  input  logic [REG_ADDR_LEN-1:0] id_rs2,
  input  logic                    id_rs2_used,
  input  logic [REG_ADDR_LEN-1:0] id_rd,
  input  logic                    id_wr,
  input  logic                    id_is_load,
  input  logic                    id_is_halt,
  input  logic                    exe_branch_taken,
  output logic                    stall,
  output logic                    bubble,
  output logic                    flush,
  output logic [SEL_W-1:0]        fwd_sel_a,
  output logic [SEL_W-1:0]        fwd_sel_b,
  output logic                    halt
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  hc_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [DEPTH-1:0]   match_a;
  logic [DEPTH-1:0]   match_b;
  logic               load_head;
  logic               haz;
  logic               accept;
  logic               running;

  pipe_scoreboard #(
    .REG_ADDR_LEN (REG_ADDR_LEN),
    .DEPTH        (DEPTH),
    .R0_ZERO      (R0_ZERO)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .push_wr   (id_wr),
    .push_rd   (id_rd),
    .push_load (id_is_load),
    .rs1       (id_rs1),
    .rs1_used  (id_rs1_used),
    .rs2       (id_rs2),
    .rs2_used  (id_rs2_used),
    .match_a   (match_a),
    .match_b   (match_b),
    .load_head (load_head)
  );

`ifdef FORWARD_EN
  // Scan oldest to youngest so the youngest producer overwrites the select.
  always_comb begin
    fwd_sel_a = '0;
    fwd_sel_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match_a[k]) fwd_sel_a = SEL_W'(k + 1);
      if (match_b[k]) fwd_sel_b = SEL_W'(k + 1);
    end
    haz = id_valid && load_head && (match_a[0] || match_b[0]);
  end
`else
  logic unused_load_head;
  assign unused_load_head = load_head;
  assign fwd_sel_a = '0;
  assign fwd_sel_b = '0;
  assign haz       = id_valid && ((|match_a) || (|match_b));
`endif

  // Gated with rst_n so a mid-cycle reset silences the flush immediately.
  assign flush   = exe_branch_taken && rst_n;
  assign running = (state == HC_RUN);
  assign stall   = (haz && !flush) || !running;
  assign bubble  = (stall || flush) && running;
  assign accept  = id_valid && !stall && !flush;
  assign halt    = (state == HC_HALTED);

  // The decremented count reaching 1 means the HALT itself sits in the last
  // entry, so every older instruction has already retired.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HC_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        HC_RUN: begin
          if (accept && id_is_halt) begin
            state <= HC_DRAIN;
            cnt   <= CNT_W'(DEPTH);
          end
        end
        HC_DRAIN: begin
          cnt <= cnt - 1'b1;
          if (int'(cnt) <= 2) state <= HC_HALTED;
        end
        HC_HALTED: state <= HC_HALTED;
        default:   state <= HC_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: two instances (R0_ZERO=1 and 0) driven
// identically and compared against a queue-based in-flight model every cycle.
module tb_pipe_hazard_ctrl;

  localparam int RW    = 5;
  localparam int DEPTH = 3;
  localparam int SW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_rs1_used, id_rs2_used, id_wr, id_is_load, id_is_halt;
  logic          exe_branch_taken;
  logic [RW-1:0] id_rs1, id_rs2, id_rd;

  logic          stall0, bubble0, flush0, halt0;
  logic [SW-1:0] fa0, fb0;
  logic          stall1, bubble1, flush1, halt1;
  logic [SW-1:0] fa1, fb1;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_LEN(RW), .DEPTH(DEPTH), .R0_ZERO(1'b1), .SEL_W(SW)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt), .exe_branch_taken(exe_branch_taken),
    .stall(stall0), .bubble(bubble0), .flush(flush0), .fwd_sel_a(fa0), .fwd_sel_b(fb0), .halt(halt0));

  pipe_hazard_ctrl #(.REG_ADDR_LEN(RW), .DEPTH(DEPTH), .R0_ZERO(1'b0), .SEL_W(SW)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt), .exe_branch_taken(exe_branch_taken),
    .stall(stall1), .bubble(bubble1), .flush(flush1), .fwd_sel_a(fa1), .fwd_sel_b(fb1), .halt(halt1));

  // One in-flight instruction; age = cycles since it left ID (0 = EXE).
  typedef struct {
    logic          wr;
    logic [RW-1:0] rd;
    logic          ld;
    int            age;
  } inst_t;
  typedef inst_t iq_t[$];

  typedef struct {
    logic          stall, bubble, flush, halt, accept;
    logic [SW-1:0] fa, fb;
  } exp_t;

  iq_t q0, q1;
  int  hacc0 = -1, hacc1 = -1;  // cycle at which HALT was accepted, -1 = none
  int  cyc   = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic exp_t eval(input iq_t q, input bit r0, input int hacc);
    exp_t e;
    int   ma = -1, mb = -1;
    bit   la = 1'b0, lb = 1'b0, haz, busy;
    foreach (q[i]) begin
      if (id_rs1_used && q[i].wr && q[i].rd == id_rs1 && !(r0 && id_rs1 == 0)) begin
        if (ma < 0 || q[i].age < ma) ma = q[i].age;
        if (q[i].age == 0 && q[i].ld) la = 1'b1;
      end
      if (id_rs2_used && q[i].wr && q[i].rd == id_rs2 && !(r0 && id_rs2 == 0)) begin
        if (mb < 0 || q[i].age < mb) mb = q[i].age;
        if (q[i].age == 0 && q[i].ld) lb = 1'b1;
      end
    end
`ifdef FORWARD_EN
    haz  = id_valid && (la || lb);
    e.fa = (ma < 0) ? '0 : SW'(ma + 1);
    e.fb = (mb < 0) ? '0 : SW'(mb + 1);
`else
    haz  = id_valid && (ma >= 0 || mb >= 0);
    e.fa = '0;
    e.fb = '0;
`endif
    busy     = (hacc >= 0) && (cyc > hacc);
    e.flush  = exe_branch_taken;
    e.stall  = (haz && !e.flush) || busy;
    e.bubble = (e.stall || e.flush) && !busy;
    e.halt   = (hacc >= 0) && (cyc >= hacc + DEPTH);
    e.accept = id_valid && !e.stall && !e.flush;
    return e;
  endfunction

  function automatic iq_t advance(input iq_t q, input logic acc);
    iq_t r;
    inst_t t;
    foreach (q[i]) begin
      if (q[i].age + 1 < DEPTH) begin
        t = q[i];
        t.age++;
        r.push_back(t);
      end
    end
    if (acc) begin
      t = '{wr: id_wr, rd: id_rd, ld: id_is_load, age: 0};
      r.push_back(t);
    end
    return r;
  endfunction

  task automatic compare(input string n, input exp_t e, input logic s, input logic b,
                         input logic f, input logic [SW-1:0] a, input logic [SW-1:0] c,
                         input logic h);
    check({n, ".stall"},  {7'd0, s}, {7'd0, e.stall});
    check({n, ".bubble"}, {7'd0, b}, {7'd0, e.bubble});
    check({n, ".flush"},  {7'd0, f}, {7'd0, e.flush});
    check({n, ".fwd_a"},  {6'd0, a}, {6'd0, e.fa});
    check({n, ".fwd_b"},  {6'd0, c}, {6'd0, e.fb});
    check({n, ".halt"},   {7'd0, h}, {7'd0, e.halt});
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    hacc0 = -1;
    hacc1 = -1;
    cyc   = 0;
  endtask

  // Check at the falling edge, advance the model at the rising edge.
  task automatic tick();
    exp_t e0, e1;
    @(negedge clk);
    if (!rst_n) begin
      e0 = '{default: '0};
      e1 = '{default: '0};
    end else begin
      e0 = eval(q0, 1'b1, hacc0);
      e1 = eval(q1, 1'b0, hacc1);
    end
    compare("r0z", e0, stall0, bubble0, flush0, fa0, fb0, halt0);
    compare("r0n", e1, stall1, bubble1, flush1, fa1, fb1, halt1);
    @(posedge clk);
    if (rst_n) begin
      if (e0.accept && id_is_halt) hacc0 = cyc;
      if (e1.accept && id_is_halt) hacc1 = cyc;
      q0 = advance(q0, e0.accept);
      q1 = advance(q1, e1.accept);
      cyc++;
    end
    #1;
  endtask

  task automatic set(input logic v, input int r1, input logic u1, input int r2, input logic u2,
                     input int rd, input logic wr, input logic ld, input logic ht, input logic bt);
    id_valid = v;   id_rs1 = RW'(r1); id_rs1_used = u1; id_rs2 = RW'(r2); id_rs2_used = u2;
    id_rd = RW'(rd); id_wr = wr; id_is_load = ld; id_is_halt = ht; exe_branch_taken = bt;
  endtask

  // Asynchronous reset between clock edges; outputs must drop at once.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.stall",  {7'd0, stall0},  8'd0);
    check("rst.bubble", {7'd0, bubble0}, 8'd0);
    check("rst.flush",  {7'd0, flush0},  8'd0);
    check("rst.fwd_a",  {6'd0, fa0},     8'd0);
    check("rst.halt",   {7'd0, halt0},   8'd0);
    check("rst1.stall", {7'd0, stall1},  8'd0);
    clear_model();
    tick();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // ADD r3, then a reader of r3
    set(1, 1, 1, 2, 1, 3, 1, 0, 0, 0); tick();
    set(1, 3, 1, 4, 1, 7, 1, 0, 0, 0); repeat (5) tick();

    // LOAD r5, then a reader of r5 (rs2 too)
    set(1, 0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
    set(1, 5, 1, 5, 1, 6, 1, 0, 0, 0); repeat (5) tick();

    // ADD r3, then a hazarding reader with a taken branch
    set(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    set(1, 3, 1, 0, 0, 8, 1, 0, 0, 1); tick();
    set(1, 3, 1, 0, 0, 8, 1, 0, 0, 0); repeat (4) tick();

    // Write r0, then read r0: stall only when r0 is an ordinary register
    set(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    set(1, 0, 1, 0, 1, 9, 1, 0, 0, 0); repeat (5) tick();

    // Reset in the middle of a stall with a branch pending
    set(1, 0, 0, 0, 0, 4, 1, 1, 0, 0); tick();
    set(1, 4, 1, 0, 0, 9, 1, 0, 0, 1); mid_reset();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) tick();

    // HALT together with a flush is squashed
    set(1, 0, 0, 0, 0, 0, 0, 0, 1, 1); tick();
    set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) tick();

    // HALT accepted behind older writers; flush during the drain
    set(1, 0, 0, 0, 0, 2, 1, 1, 0, 0); tick();
    set(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); tick();
    set(1, 2, 1, 0, 0, 3, 1, 0, 0, 0); tick();
    set(1, 2, 1, 0, 0, 3, 1, 0, 0, 1); tick();
    set(1, 2, 1, 0, 0, 3, 1, 0, 0, 0); repeat (4) tick();
    mid_reset();

    // Randomised traffic over a small register range to provoke hazards
    for (int n = 0; n < 800; n++) begin
      set($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
          $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
          $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0);
      tick();
      if ((hacc0 >= 0 && cyc >= hacc0 + DEPTH + 2) || (hacc1 >= 0 && cyc >= hacc1 + DEPTH + 2) ||
          $urandom_range(0, 199) == 0)
        mid_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
